// File: rtl/pipe_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_pkg
// Description : Shared forwarding-select encodings and register-number helpers
//               for the 5-stage pipeline operand forwarding control.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_fwd_pkg;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EALU = 2'd1;
    localparam logic [1:0] FWD_MALU = 2'd2;
    localparam logic [1:0] FWD_MMO  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A stage supplies a value for src only if it writes a real register equal to src.
    function automatic logic reg_hit(input logic       wreg,
                                     input logic [4:0] dst,
                                     input logic [4:0] src);
        return wreg && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage : pipe_fwd_pkg
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_sel
// Description : Combinational forward-select for one ID source register,
//               prioritising the EXE stage over the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_sel
    import pipe_fwd_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mrn,
    output logic [1:0] sel
);

    logic w_ehit;
    logic w_mhit;

    assign w_ehit = reg_hit(ewreg, ern, src);
    assign w_mhit = reg_hit(mwreg, mrn, src);

    // A load in EXE has no value yet; it falls through so an older MEM hit can still match.
    always_comb begin
        sel = FWD_RF;
        if (w_ehit && !em2reg) begin
            sel = FWD_EALU;
        end else if (w_mhit) begin
            sel = mm2reg ? FWD_MMO : FWD_MALU;
        end
    end

endmodule : pipe_fwd_sel
`default_nettype wire

// File: rtl/pipe_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fwd_ctrl
// Description : ID-stage operand forwarding, load-use stall and stall counter,
//               tracking EXE results through MEM/WB shadow registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_ctrl
    import pipe_fwd_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ern,
    input  logic [31:0]      ealu,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [31:0]      mmo,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             usert,
    input  logic [31:0]      qa,
    input  logic [31:0]      qb,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [31:0]      da,
    output logic [31:0]      db,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_mwreg;
    logic             r_mm2reg;
    logic [4:0]       r_mrn;
    logic [31:0]      r_malu;
    logic             r_wwreg;
    logic [4:0]       r_wrn;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0]      w_rfa;
    logic [31:0]      w_rfb;
    logic             w_wb_en;

    // Shadow stages free-run: the downstream pipeline never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mwreg  <= 1'b0;
            r_mm2reg <= 1'b0;
            r_mrn    <= REG_ZERO;
            r_malu   <= 32'd0;
            r_wwreg  <= 1'b0;
            r_wrn    <= REG_ZERO;
            r_wdata  <= 32'd0;
        end else begin
            r_mwreg  <= ewreg;
            r_mm2reg <= em2reg;
            r_mrn    <= ern;
            r_malu   <= ealu;
            r_wwreg  <= r_mwreg;
            r_wrn    <= r_mrn;
            r_wdata  <= r_mm2reg ? mmo : r_malu;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

    assign stall = ewreg && em2reg && (ern != REG_ZERO) &&
                   ((ern == rs) || (usert && (ern == rt)));

    pipe_fwd_sel u_sel_a (
        .src    (rs),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ern    (ern),
        .mwreg  (r_mwreg),
        .mm2reg (r_mm2reg),
        .mrn    (r_mrn),
        .sel    (fwda)
    );

    pipe_fwd_sel u_sel_b (
        .src    (rt),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ern    (ern),
        .mwreg  (r_mwreg),
        .mm2reg (r_mm2reg),
        .mrn    (r_mrn),
        .sel    (fwdb)
    );

    // The register file has no write-through, so a WB-stage result shadows the stale read.
    assign w_wb_en = (WB_BYPASS != 0) && r_wwreg;
    assign w_rfa   = reg_hit(w_wb_en, r_wrn, rs) ? r_wdata : qa;
    assign w_rfb   = reg_hit(w_wb_en, r_wrn, rt) ? r_wdata : qb;

    always_comb begin
        da = w_rfa;
        case (fwda)
            FWD_EALU: da = ealu;
            FWD_MALU: da = r_malu;
            FWD_MMO:  da = mmo;
            default:  da = w_rfa;
        endcase
    end

    always_comb begin
        db = w_rfb;
        case (fwdb)
            FWD_EALU: db = ealu;
            FWD_MALU: db = r_malu;
            FWD_MMO:  db = mmo;
            default:  db = w_rfb;
        endcase
    end

endmodule : pipe_fwd_ctrl
`default_nettype wire

// File: tb/tb_pipe_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_fwd_ctrl
// Description : Self-checking bench for pipe_fwd_ctrl (default and
//               no-bypass / 2-bit counter configurations) against a
//               history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ern;
    logic [31:0] ealu;
    logic        ewreg;
    logic        em2reg;
    logic [31:0] mmo;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usert;
    logic [31:0] qa;
    logic [31:0] qb;

    logic [1:0]  fwda, fwdb;
    logic [31:0] da, db;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [1:0]  nb_fwda, nb_fwdb;
    logic [31:0] nb_da, nb_db;
    logic        nb_stall;
    logic [1:0]  nb_stall_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_fwd_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dut (
        .clock(clk), .reset(rst), .ern(ern), .ealu(ealu), .ewreg(ewreg),
        .em2reg(em2reg), .mmo(mmo), .rs(rs), .rt(rt), .usert(usert),
        .qa(qa), .qb(qb), .fwda(fwda), .fwdb(fwdb), .da(da), .db(db),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    pipe_fwd_ctrl #(.WB_BYPASS(0), .CNT_W(2)) dut_nb (
        .clock(clk), .reset(rst), .ern(ern), .ealu(ealu), .ewreg(ewreg),
        .em2reg(em2reg), .mmo(mmo), .rs(rs), .rt(rt), .usert(usert),
        .qa(qa), .qb(qb), .fwda(nb_fwda), .fwdb(nb_fwdb), .da(nb_da), .db(nb_db),
        .stall(nb_stall), .stall_cnt(nb_stall_cnt)
    );

    // Reference model: what the instruction issued one and two cycles ago left behind.
    typedef struct {
        bit          wr;
        bit          ld;
        bit [4:0]    rn;
        bit [31:0]   val;
    } older_t;

    older_t m1;   // instruction that left EXE one edge ago
    older_t m2;   // instruction that left EXE two edges ago (val = final written data)
    int     cnt_a;
    int     cnt_b;

    function automatic bit writes(older_t o, bit [4:0] r);
        return o.wr && r != 0 && o.rn == r;
    endfunction

    function automatic bit [1:0] exp_sel(bit [4:0] r);
        if (ewreg && ern != 0 && ern == r && !em2reg) return 2'd1;
        if (writes(m1, r)) return m1.ld ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic bit [31:0] exp_val(bit [4:0] r, bit [31:0] q, bit bypass);
        case (exp_sel(r))
            2'd1: return ealu;
            2'd2: return m1.val;
            2'd3: return mmo;
            default: return (bypass && writes(m2, r)) ? m2.val : q;
        endcase
    endfunction

    function automatic bit exp_stall();
        return ewreg && em2reg && ern != 0 && (ern == rs || (usert && ern == rt));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fwda"},     32'(fwda),         32'(exp_sel(rs)));
        chk({tag, ".fwdb"},     32'(fwdb),         32'(exp_sel(rt)));
        chk({tag, ".da"},       da,                exp_val(rs, qa, 1'b1));
        chk({tag, ".db"},       db,                exp_val(rt, qb, 1'b1));
        chk({tag, ".stall"},    32'(stall),        32'(exp_stall()));
        chk({tag, ".cnt"},      32'(stall_cnt),    32'(cnt_a));
        chk({tag, ".nb_da"},    nb_da,             exp_val(rs, qa, 1'b0));
        chk({tag, ".nb_db"},    nb_db,             exp_val(rt, qb, 1'b0));
        chk({tag, ".nb_stall"}, 32'(nb_stall),     32'(exp_stall()));
        chk({tag, ".nb_cnt"},   32'(nb_stall_cnt), 32'(cnt_b));
    endtask

    task automatic model_edge();
        bit s;
        s = exp_stall();
        if (rst) begin
            m1 = '{0, 0, 0, 0};
            m2 = '{0, 0, 0, 0};
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            m2 = '{m1.wr, m1.ld, m1.rn, m1.ld ? mmo : m1.val};
            m1 = '{ewreg, em2reg, ern, ealu};
            if (s) begin
                cnt_a = (cnt_a == 65535) ? cnt_a : cnt_a + 1;
                cnt_b = (cnt_b == 3) ? cnt_b : cnt_b + 1;
            end
        end
    endtask

    // Inputs are driven at the falling edge; this settles, checks, then crosses the rising edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; ern = 0; ealu = 0; ewreg = 0; em2reg = 0; mmo = 0;
        rs = 0; rt = 0; usert = 0; qa = 32'h11; qb = 32'h22;
    endtask

    initial begin
        m1 = '{0, 0, 0, 0};
        m2 = '{0, 0, 0, 0};
        cnt_a = 0;
        cnt_b = 0;
        idle();
        rst = 1;
        @(negedge clk);
        @(posedge clk); model_edge();
        @(negedge clk);
        rs = 5'd4; rt = 5'd7;
        cycle("reset");
        chk("reset.fwda0", 32'(fwda), 32'd0);
        chk("reset.da_qa", da, 32'h11);

        idle();
        cycle("idle");

        // EXE hit
        ewreg = 1; ern = 5; ealu = 32'h1234; rs = 5;
        #1;
        chk("exe.fwda", 32'(fwda), 32'd1);
        chk("exe.da", da, 32'h1234);
        cycle("exe");

        // MEM load hit one cycle after the load left EXE
        idle(); ewreg = 1; em2reg = 1; ern = 8;
        cycle("ld_issue");
        idle(); mmo = 32'hCAFE; rt = 8; usert = 1;
        #1;
        chk("memld.fwdb", 32'(fwdb), 32'd3);
        chk("memld.db", db, 32'hCAFE);
        cycle("memld");

        // Load-use stall: one bubble, then the value comes from mmo
        idle(); ewreg = 1; em2reg = 1; ern = 9; rs = 9;
        #1;
        chk("lu.stall", 32'(stall), 32'd1);
        cycle("lu");
        idle(); rs = 9; mmo = 32'hBEEF;
        #1;
        chk("lu.after_stall", 32'(stall), 32'd0);
        chk("lu.after_fwda", 32'(fwda), 32'd3);
        chk("lu.cnt1", 32'(stall_cnt), 32'd1);
        cycle("lu_after");

        // Load matching rt but rt unused as operand
        idle(); ewreg = 1; em2reg = 1; ern = 10; rt = 10; rs = 1; usert = 0;
        #1;
        chk("usert0.stall", 32'(stall), 32'd0);
        cycle("usert0");

        // EXE beats MEM on the same register
        idle(); ewreg = 1; ern = 3; ealu = 32'hB;
        cycle("prio_mem");
        idle(); ewreg = 1; ern = 3; ealu = 32'hA; rs = 3;
        #1;
        chk("prio.da", da, 32'hA);
        cycle("prio");

        // Register zero never forwards
        idle(); ewreg = 1; ern = 0; ealu = 32'h55; rs = 0; qa = 32'h99;
        #1;
        chk("zero.fwda", 32'(fwda), 32'd0);
        chk("zero.da", da, 32'h99);
        cycle("zero");

        // WB bypass of a stale register-file read
        idle(); ewreg = 1; ern = 12; ealu = 32'h77;
        cycle("wb_issue");
        idle();
        cycle("wb_mem");
        idle(); rs = 12; qa = 32'h0;
        #1;
        chk("wb.fwda", 32'(fwda), 32'd0);
        chk("wb.da", da, 32'h77);
        chk("wb.nb_da", nb_da, 32'h0);
        cycle("wb");

        // Reset mid-stream
        idle(); ewreg = 1; ern = 5; ealu = 32'h4242; rs = 5;
        cycle("rst_hit");
        idle(); rst = 1; rs = 5; rt = 5;
        cycle("rst_edge");
        idle(); rs = 5; rt = 5;
        #1;
        chk("rst.fwda", 32'(fwda), 32'd0);
        chk("rst.fwdb", 32'(fwdb), 32'd0);
        chk("rst.cnt", 32'(stall_cnt), 32'd0);
        cycle("rst_after");

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            idle(); ewreg = 1; em2reg = 1; ern = 9; rs = 9;
            cycle("sat");
        end
        #1;
        chk("sat.nb_cnt", 32'(nb_stall_cnt), 32'd3);
        chk("sat.cnt", 32'(stall_cnt), 32'd5);

        // Randomised traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            ern    = 5'($urandom_range(0, 3));
            ealu   = $urandom;
            ewreg  = 1'($urandom_range(0, 1));
            em2reg = 1'($urandom_range(0, 1));
            mmo    = $urandom;
            rs     = 5'($urandom_range(0, 3));
            rt     = 5'($urandom_range(0, 3));
            usert  = 1'($urandom_range(0, 1));
            qa     = $urandom;
            qb     = $urandom;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_fwd_ctrl
`default_nettype wire

// File: doc/pipe_fwd_ctrl.md
Name: pipe_fwd_ctrl

Overview:
- Consumer-side counterpart of the EXE stage of the 5-stage MIPS pipeline.
- Takes the EXE-stage result tuple (ern, ealu, ewreg, em2reg) and tracks it through internal MEM and WB shadow registers.
- Drives ID-stage operand forwarding selects, forwarded operand values, the load-use stall, and a stall performance counter.
- Sits beside the ID stage. Replaces the ad-hoc forwarding logic in the ID decode path.

Parameters:
- WB_BYPASS, 1, when 1 the WB-stage result overrides the register-file read (register file has no write-through); when 0 the WB stage is never a forwarding source.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ern  in  5  EXE destination register (already forced to 31 for jal).
- ealu  in  32  EXE result (ALU result or pc+8).
- ewreg  in  1  EXE instruction writes a register; the ID/EXE register zeroes this for bubbles.
- em2reg  in  1  EXE instruction is a load.
- mmo  in  32  data-memory read data for the instruction currently in MEM.
- rs  in  5  ID source register A.
- rt  in  5  ID source register B.
- usert  in  1  ID instruction reads rt as an operand.
- qa  in  32  register-file read data for rs.
- qb  in  32  register-file read data for rt.
- fwda  out  2  A select: 0 rf/WB, 1 ealu, 2 malu, 3 mmo.
- fwdb  out  2  B select, same encoding.
- da  out  32  forwarded A operand.
- db  out  32  forwarded B operand.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE.
- stall_cnt  out  CNT_W  count of stalled cycles.

Behaviour:
- MEM shadow register, updated every cycle with no enable: mwreg<=ewreg, mm2reg<=em2reg, mrn<=ern, malu<=ealu.
- WB shadow register, updated every cycle: wwreg<=mwreg, wrn<=mrn, wdata<=(mm2reg ? mmo : malu).
- Reset: mwreg, wwreg, mm2reg <= 0; mrn, wrn <= 0; malu, wdata <= 0; stall_cnt <= 0.
- Reset outputs: fwda=fwdb=0, stall=0, da=qa, db=qb (no stage valid).
- Forward-select for operand A (first match wins):
  - ewreg && ern!=0 && ern==rs && !em2reg -> 1
  - mwreg && mrn!=0 && mrn==rs && !mm2reg -> 2
  - mwreg && mrn!=0 && mrn==rs && mm2reg -> 3
  - else -> 0
- Operand B uses the same rule with rt.
- Register 0 never matches any stage.
- Source value 0: if WB_BYPASS && wwreg && wrn!=0 && wrn==reg, use wdata; else use qa/qb.
- The WB bypass is not encoded in fwda/fwdb; it applies only to value 0.
- Load-use stall: stall = ewreg && em2reg && ern!=0 && (ern==rs || (usert && ern==rt)). Combinational.
- While stalled, fwda/fwdb/da/db are don't-care for the consumer but are still computed by the rule above.
- Stall latency: the load reaches MEM on the next edge, so the following cycle selects 3 (mmo). One bubble per load-use.
- Shadow registers advance during a stall; the downstream pipeline never stalls.
- stall_cnt increments by 1 on each rising edge with stall=1 and reset=0. It saturates at all-ones and does not wrap.
- Reset asserted mid-stream clears all shadow state in the same edge. The next cycle forwards nothing.
- Simultaneous EXE and MEM hit on the same register: EXE wins (youngest value). Same rule for MEM over WB.

Decomposition:
- Shared pipeline package: forwarding-select constants FWD_RF=0, FWD_EALU=1, FWD_MALU=2, FWD_MMO=3, and REG_ZERO=5'd0.
- One sub-module, pipe_fwd_sel, is combinational: one register number plus stage tags in, 2-bit select out. It is instantiated twice (rs, rt).
- Shadow registers, value muxes, stall and counter stay in the top module.

Test Plan:
- EXE hit: ewreg=1, em2reg=0, ern=5, ealu=32'h1234, rs=5 -> fwda=1, da=32'h1234, stall=0.
- MEM load hit, one cycle after the load left EXE: ern=8, em2reg=1, then mmo=32'hCAFE, rt=8, usert=1 -> fwdb=3, db=32'hCAFE.
- Load-use stall: ewreg=1, em2reg=1, ern=9, rs=9 -> stall=1 for exactly one cycle; stall_cnt 0->1.
- usert=0 with ern==rt load -> stall=0.
- Priority and zero register: EXE ern=3 (ealu=32'hA), MEM mrn=3 (malu=32'hB), rs=3 -> da=32'hA. ern=0, rs=0 with ewreg=1 -> fwda=0, da=qa.
- WB bypass (WB_BYPASS=1): value written to r12 two cycles earlier, rs=12, qa stale 32'h0 -> fwda=0, da=wdata. With WB_BYPASS=0 -> da=qa.
- Reset mid-stream: drive an EXE hit, assert reset one edge -> next cycle fwda=fwdb=0 and stall_cnt=0.
- Counter saturation: set CNT_W=2 and hold stall for 5 cycles -> stall_cnt=3.
